// File: rtl/alu_pkg.sv
// Shared definitions for the MULTI_FUNC_ALU datapath and the sequencer that
// drives it: default widths, the opcode map and the sequencer FSM encoding.
// No ports; imported by every file that talks to the ALU.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OP_W_DEF  = 3;

  localparam logic [OP_W_DEF-1:0] OP_AND = 3'd0;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W_DEF-1:0] OP_NOR = 3'd3;
  localparam logic [OP_W_DEF-1:0] OP_ADD = 3'd4;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 3'd5;
  localparam logic [OP_W_DEF-1:0] OP_SLT = 3'd6;
  localparam logic [OP_W_DEF-1:0] OP_SLL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high clear
//   inc   - count one event this cycle
//   count - current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Hold at all-ones once reached so the harness never sees a wrapped value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for MULTI_FUNC_ALU. A command accepted in IDLE is
// registered onto the ALU inputs, the ALU result and flags are captured at
// the end of EXEC, and the response is held in RESP until taken.
// Ports:
//   ALU_OP_SEQ_clk_xi / _rst_xi            - clock, synchronous active-high reset
//   ALU_OP_SEQ_cmd_*                       - command channel (valid/ready, A, B, OP, chain)
//   ALU_OP_SEQ_alu_A/B/OP_xo               - registered operands to the ALU
//   ALU_OP_SEQ_alu_F/overflow/zero_xi      - ALU result and flags
//   ALU_OP_SEQ_rsp_*                       - response channel (valid/ready, F, flags)
//   ALU_OP_SEQ_op_count_xo / _ovf_count_xo - saturating statistics
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             ALU_OP_SEQ_clk_xi,
  input  logic             ALU_OP_SEQ_rst_xi,
  input  logic             ALU_OP_SEQ_cmd_valid_xi,
  output logic             ALU_OP_SEQ_cmd_ready_xo,
  input  logic [WIDTH-1:0] ALU_OP_SEQ_cmd_A_xi,
  input  logic [WIDTH-1:0] ALU_OP_SEQ_cmd_B_xi,
  input  logic [OP_W-1:0]  ALU_OP_SEQ_cmd_OP_xi,
  input  logic             ALU_OP_SEQ_cmd_chain_xi,
  output logic [WIDTH-1:0] ALU_OP_SEQ_alu_A_xo,
  output logic [WIDTH-1:0] ALU_OP_SEQ_alu_B_xo,
  output logic [OP_W-1:0]  ALU_OP_SEQ_alu_OP_xo,
  input  logic [WIDTH-1:0] ALU_OP_SEQ_alu_F_xi,
  input  logic             ALU_OP_SEQ_alu_overflow_xi,
  input  logic             ALU_OP_SEQ_alu_zero_xi,
  output logic             ALU_OP_SEQ_rsp_valid_xo,
  input  logic             ALU_OP_SEQ_rsp_ready_xi,
  output logic [WIDTH-1:0] ALU_OP_SEQ_rsp_F_xo,
  output logic             ALU_OP_SEQ_rsp_overflow_xo,
  output logic             ALU_OP_SEQ_rsp_zero_xo,
  output logic [CNT_W-1:0] ALU_OP_SEQ_op_count_xo,
  output logic [CNT_W-1:0] ALU_OP_SEQ_ovf_count_xo
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             op_inc;
  logic             ovf_inc;

  // Next-state and datapath load decisions. Everything holds by default so
  // the ALU operands and captured response stay put between commands.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_f_d    = rsp_f_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_zero_d = rsp_zero_q;
    last_d     = last_q;
    op_inc     = 1'b0;
    ovf_inc    = 1'b0;
    ALU_OP_SEQ_cmd_ready_xo = 1'b0;
    ALU_OP_SEQ_rsp_valid_xo = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ALU_OP_SEQ_cmd_ready_xo = 1'b1;
        if (ALU_OP_SEQ_cmd_valid_xi) begin
          alu_a_d  = ALU_OP_SEQ_cmd_chain_xi ? last_q : ALU_OP_SEQ_cmd_A_xi;
          alu_b_d  = ALU_OP_SEQ_cmd_B_xi;
          alu_op_d = ALU_OP_SEQ_cmd_OP_xi;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU is purely combinational, so its outputs are settled by the
        // end of this cycle and can be captured directly.
        rsp_f_d    = ALU_OP_SEQ_alu_F_xi;
        rsp_ovf_d  = ALU_OP_SEQ_alu_overflow_xi;
        rsp_zero_d = ALU_OP_SEQ_alu_zero_xi;
        last_d     = ALU_OP_SEQ_alu_F_xi;
        op_inc     = 1'b1;
        ovf_inc    = ALU_OP_SEQ_alu_overflow_xi;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        ALU_OP_SEQ_rsp_valid_xo = 1'b1;
        if (ALU_OP_SEQ_rsp_ready_xi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset drops any in-flight command: no response, no counter update.
  always_ff @(posedge ALU_OP_SEQ_clk_xi) begin
    if (ALU_OP_SEQ_rst_xi) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_f_q    <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_f_q    <= rsp_f_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_zero_q <= rsp_zero_d;
      last_q     <= last_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_op_count (
    .clk   (ALU_OP_SEQ_clk_xi),
    .rst   (ALU_OP_SEQ_rst_xi),
    .inc   (op_inc),
    .count (ALU_OP_SEQ_op_count_xo)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ovf_count (
    .clk   (ALU_OP_SEQ_clk_xi),
    .rst   (ALU_OP_SEQ_rst_xi),
    .inc   (ovf_inc),
    .count (ALU_OP_SEQ_ovf_count_xo)
  );

  assign ALU_OP_SEQ_alu_A_xo        = alu_a_q;
  assign ALU_OP_SEQ_alu_B_xo        = alu_b_q;
  assign ALU_OP_SEQ_alu_OP_xo       = alu_op_q;
  assign ALU_OP_SEQ_rsp_F_xo        = rsp_f_q;
  assign ALU_OP_SEQ_rsp_overflow_xo = rsp_ovf_q;
  assign ALU_OP_SEQ_rsp_zero_xo     = rsp_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer wired to a behavioural
// MULTI_FUNC_ALU. Directed vectors, hand-written reset/backpressure
// sequences and randomized commands checked against a transaction model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int OP_W    = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_chain;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_f;
  logic [OP_W-1:0]  alu_op;
  logic             alu_ovf, alu_zero;
  logic             rsp_valid, rsp_ready, rsp_ovf, rsp_zero;
  logic [WIDTH-1:0] rsp_f;
  logic [CNT_W-1:0] op_count, ovf_count;

  int num_compared   = 0;
  int num_mismatched = 0;

  // Transaction-level model of the sequencer's visible state.
  logic [WIDTH-1:0] model_last;
  int               model_ops;
  int               model_ovfs;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .ALU_OP_SEQ_clk_xi          (clk),
    .ALU_OP_SEQ_rst_xi          (rst),
    .ALU_OP_SEQ_cmd_valid_xi    (cmd_valid),
    .ALU_OP_SEQ_cmd_ready_xo    (cmd_ready),
    .ALU_OP_SEQ_cmd_A_xi        (cmd_a),
    .ALU_OP_SEQ_cmd_B_xi        (cmd_b),
    .ALU_OP_SEQ_cmd_OP_xi       (cmd_op),
    .ALU_OP_SEQ_cmd_chain_xi    (cmd_chain),
    .ALU_OP_SEQ_alu_A_xo        (alu_a),
    .ALU_OP_SEQ_alu_B_xo        (alu_b),
    .ALU_OP_SEQ_alu_OP_xo       (alu_op),
    .ALU_OP_SEQ_alu_F_xi        (alu_f),
    .ALU_OP_SEQ_alu_overflow_xi (alu_ovf),
    .ALU_OP_SEQ_alu_zero_xi     (alu_zero),
    .ALU_OP_SEQ_rsp_valid_xo    (rsp_valid),
    .ALU_OP_SEQ_rsp_ready_xi    (rsp_ready),
    .ALU_OP_SEQ_rsp_F_xo        (rsp_f),
    .ALU_OP_SEQ_rsp_overflow_xo (rsp_ovf),
    .ALU_OP_SEQ_rsp_zero_xo     (rsp_zero),
    .ALU_OP_SEQ_op_count_xo     (op_count),
    .ALU_OP_SEQ_ovf_count_xo    (ovf_count)
  );

  // Behavioural MULTI_FUNC_ALU: returns {overflow, zero, F}.
  function automatic logic [WIDTH+1:0] aluRef(input logic [OP_W-1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] f;
    logic             ovf;
    ovf = 1'b0;
    case (op)
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_NOR: f = ~(a | b);
      OP_ADD: begin
        f   = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        f   = a - b;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = a << b[4:0];
    endcase
    return {ovf, (f == '0), f};
  endfunction

  assign {alu_ovf, alu_zero, alu_f} = aluRef(alu_op, alu_a, alu_b);

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             chain;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_f;
    logic             exp_ovf;
    logic             exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    model_last = '0;
    model_ops  = 0;
    model_ovfs = 0;
  endtask

  // One full command: accept, EXEC, RESP held for 'hold' cycles (optionally
  // with ignored commands offered), then handshake and check the hold-over.
  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic chain,
                               input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_f,
                               input logic exp_ovf, input logic exp_zero,
                               input int hold, input logic junk);
    @(negedge clk);
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_chain = 1'b0;
    checkOutput("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    checkOutput("cmd_ready_exec", 32'(cmd_ready), 32'd0);
    checkOutput("alu_A", alu_a, exp_a);
    checkOutput("alu_B", alu_b, b);
    checkOutput("alu_OP", 32'(alu_op), 32'(op));
    if (model_ops < CNT_MAX) model_ops++;
    if (exp_ovf && (model_ovfs < CNT_MAX)) model_ovfs++;
    model_last = exp_f;
    @(negedge clk);
    checkOutput("rsp_valid_resp", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_F", rsp_f, exp_f);
    checkOutput("rsp_overflow", 32'(rsp_ovf), 32'(exp_ovf));
    checkOutput("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
    checkOutput("op_count", 32'(op_count), 32'(model_ops));
    checkOutput("ovf_count", 32'(ovf_count), 32'(model_ovfs));
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom;
        cmd_op = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      checkOutput("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_F_hold", rsp_f, exp_f);
      checkOutput("cmd_ready_hold", 32'(cmd_ready), 32'd0);
      checkOutput("alu_B_hold", alu_b, b);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_after", 32'(rsp_valid), 32'd0);
    checkOutput("cmd_ready_after", 32'(cmd_ready), 32'd1);
    checkOutput("rsp_F_after", rsp_f, exp_f);
    checkOutput("alu_A_after", alu_a, exp_a);
    checkOutput("op_count_after", 32'(op_count), 32'(model_ops));
  endtask

  initial begin
    logic [WIDTH+1:0] ref_res;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_a, r_b, r_expa;
    logic             r_chain;

    vecs[0] = '{OP_OR,  32'h0000_1234, 32'd9,        1'b1, 32'd0,        32'd9,        1'b0, 1'b0};
    vecs[1] = '{OP_ADD, 32'd3,         32'd4,        1'b0, 32'd3,        32'd7,        1'b0, 1'b0};
    vecs[2] = '{OP_ADD, 32'h7FFF_FFFF, 32'd1,        1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
    vecs[3] = '{OP_SUB, 32'd5,         32'd5,        1'b0, 32'd5,        32'd0,        1'b0, 1'b1};
    vecs[4] = '{OP_ADD, 32'd10,        32'd5,        1'b0, 32'd10,       32'd15,       1'b0, 1'b0};
    vecs[5] = '{OP_ADD, 32'h0000_DEAD, 32'd1,        1'b1, 32'd15,       32'd16,       1'b0, 1'b0};
    vecs[6] = '{OP_SLT, 32'hFFFF_FFFF, 32'd1,        1'b0, 32'hFFFF_FFFF, 32'd1,        1'b0, 1'b0};
    vecs[7] = '{OP_SLL, 32'd1,         32'd31,       1'b0, 32'd1,        32'h8000_0000, 1'b0, 1'b0};
    vecs[8] = '{OP_NOR, 32'd0,         32'd0,        1'b0, 32'd0,        32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9] = '{OP_SUB, 32'h8000_0000, 32'd1,        1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};

    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_chain = 1'b0;
    rsp_ready = 1'b0;

    // Reset for two cycles, then every output is cleared and ready is up.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_alu_A", alu_a, 32'd0);
    checkOutput("reset_alu_B", alu_b, 32'd0);
    checkOutput("reset_alu_OP", 32'(alu_op), 32'd0);
    checkOutput("reset_rsp_F", rsp_f, 32'd0);
    checkOutput("reset_rsp_flags", {30'd0, rsp_ovf, rsp_zero}, 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    checkOutput("reset_ovf_count", 32'(ovf_count), 32'd0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain, vecs[i].exp_a,
                    vecs[i].exp_f, vecs[i].exp_ovf, vecs[i].exp_zero, i % 3, 1'(i % 2));
    end

    // Backpressure for 5 cycles in RESP, then reset drops the response.
    $display("[TB] backpressure then reset in RESP");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 32'd10; cmd_b = 32'd20; cmd_op = OP_ADD; cmd_chain = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int h = 0; h < 5; h++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_F", rsp_f, 32'd30);
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_resp_op_count", 32'(op_count), 32'd0);
    checkOutput("rst_resp_ovf_count", 32'(ovf_count), 32'd0);
    checkOutput("rst_resp_rsp_F", rsp_f, 32'd0);
    checkOutput("rst_resp_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    checkOutput("rst_resp_rsp_valid_2", 32'(rsp_valid), 32'd0);

    // Reset while in EXEC: the command never completes or counts.
    $display("[TB] reset in EXEC");
    cmd_valid = 1'b1; cmd_a = 32'h7FFF_FFFF; cmd_b = 32'd1; cmd_op = OP_ADD;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_exec_op_count", 32'(op_count), 32'd0);
    checkOutput("rst_exec_ovf_count", 32'(ovf_count), 32'd0);
    checkOutput("rst_exec_alu_A", alu_a, 32'd0);
    @(negedge clk);
    checkOutput("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_exec_op_count_2", 32'(op_count), 32'd0);

    // Randomized commands; first one chains from the cleared last result.
    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: r_a = $urandom;
        1: r_a = 32'h7FFF_FFFF;
        2: r_a = 32'h8000_0000;
        default: r_a = 32'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0: r_b = $urandom;
        1: r_b = 32'h0000_0001;
        2: r_b = 32'hFFFF_FFFF;
        default: r_b = 32'($urandom_range(0, 31));
      endcase
      r_chain = (i == 0) || ($urandom_range(0, 3) == 0);
      r_expa  = r_chain ? model_last : r_a;
      ref_res = aluRef(r_op, r_expa, r_b);
      applyStimulus(r_op, r_a, r_b, r_chain, r_expa, ref_res[WIDTH-1:0],
                    ref_res[WIDTH+1], ref_res[WIDTH], $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end
    checkOutput("op_count_saturated", 32'(op_count), 32'(CNT_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
